jtag_master: RTL

JTAG_MASTER -- requirements
Module: jtag_master

---
 rtl/jtag_pkg.sv | 28 ++
 rtl/jtag_master_if.sv | 22 ++
 rtl/jtag_tck_gen.sv | 43 ++++
 rtl/jtag_master.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG master definitions: command encodings, FSM states and TAP instruction codes.
package jtag_pkg;

  typedef enum logic [1:0] {
    CMD_RESET = 2'd0,
    CMD_IR    = 2'd1,
    CMD_DR    = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_DONE
  } state_e;

  localparam logic [3:0] INS_SAMPLE   = 4'h1;
  localparam logic [3:0] INS_EXTEST   = 4'h2;
  localparam logic [3:0] INS_INTEST   = 4'h3;
  localparam logic [3:0] INS_RUNBIST  = 4'h4;
  localparam logic [3:0] INS_GETTEST  = 4'h5;
  localparam logic [3:0] INS_IDCODE   = 4'h7;
  localparam logic [3:0] INS_USERCODE = 4'h8;
  localparam logic [3:0] INS_BYPASS   = 4'hF;

endpackage

// File: rtl/jtag_master_if.sv
// Command/response bus of the JTAG master; master = command issuer, slave = jtag_master.
interface jtag_master_if #(
  parameter int DR_WIDTH = 10
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_type;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_data;
  logic                busy;

  modport master (
    output cmd_valid, cmd_type, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK divider: toggles every CLK_DIV clk cycles while enabled, idles low otherwise.
// rise_o/fall_o flag the clk cycle whose closing edge drives TCK high/low.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          tck_q, tck_d;
  logic          term;

  assign term = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    div_d = '0;
    tck_d = 1'b0;
    if (en_i) begin
      tck_d = tck_q ^ term;
      div_d = term ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o  = tck_q;
  assign rise_o = en_i & term & ~tck_q;
  assign fall_o = en_i & term & tck_q;
endmodule

// File: rtl/jtag_master.sv
// JTAG master: runs TAP reset, IR scan and DR scan commands from Run-Test/Idle back to it.
// TMS/TDI are registered and only updated on TCK falling steps; TDO is captured on rising steps.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = 4,
  parameter int DR_WIDTH = 10,
  parameter int CLK_DIV  = 2
) (
  input  logic           clk,
  input  logic           rst,
  jtag_master_if.slave   bus,
  output logic           TCK,
  output logic           TMS,
  output logic           TDI,
  input  logic           TDO
);
  localparam int MAXL = (DR_WIDTH > 6) ? DR_WIDTH : 6;
  localparam int CW   = $clog2(MAXL + 1);
  typedef logic [CW-1:0] cnt_t;

  state_e              state_q, state_d;
  cmd_e                type_q, type_d;
  cnt_t                cnt_q, cnt_d;
  logic [DR_WIDTH-1:0] data_q, data_d, cap_q, cap_d;
  logic                tms_q, tms_d, tdi_q, tdi_d;
  logic                busy, accept, tck_rise, tck_fall, last_step;
  cnt_t                shift_len, step_len;

  assign busy          = state_q inside {ST_PRE, ST_SHIFT, ST_POST};
  assign bus.busy      = busy;
  assign bus.cmd_ready = !busy && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.rsp_valid = (state_q == ST_DONE);
  // IR capture fills the top of cap_q, so shift it down to right-align.
  assign bus.rsp_data  = (state_q != ST_DONE) ? '0 :
                         (type_q == CMD_IR)   ? cap_q >> (DR_WIDTH - IR_WIDTH) :
                         (type_q == CMD_DR)   ? cap_q : '0;

  assign shift_len = (type_q == CMD_IR) ? cnt_t'(IR_WIDTH) : cnt_t'(DR_WIDTH);

  always_comb begin
    step_len = cnt_t'(2);
    case (state_q)
      ST_PRE:   step_len = (type_q == CMD_RESET) ? cnt_t'(6) :
                           (type_q == CMD_IR)    ? cnt_t'(4) : cnt_t'(3);
      ST_SHIFT: step_len = shift_len;
      default:  step_len = cnt_t'(2);
    endcase
  end

  assign last_step = (cnt_q == step_len - cnt_t'(1));

  function automatic logic tms_for(state_e s, cmd_e t, cnt_t c, cnt_t slen);
    logic v;
    v = 1'b0;
    case (s)
      ST_PRE: begin
        case (t)
          CMD_RESET: v = (c < cnt_t'(5));
          CMD_IR:    v = (c < cnt_t'(2));
          default:   v = (c == '0);
        endcase
      end
      ST_SHIFT: v = (c == slen - cnt_t'(1));
      ST_POST:  v = (c == '0);
      default:  v = 1'b0;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    cap_d   = cap_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          type_d = cmd_e'(bus.cmd_type);
          data_d = bus.cmd_data;
          cap_d  = '0;
          cnt_d  = '0;
          tdi_d  = 1'b0;
          if (type_d == CMD_RSVD) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PRE;
            tms_d   = 1'b1;
          end
        end
      end
      default: begin
        if (tck_rise && state_q == ST_SHIFT) cap_d = {TDO, cap_q[DR_WIDTH-1:1]};
        if (tck_fall) begin
          cnt_d = cnt_q + cnt_t'(1);
          if (last_step) begin
            cnt_d = '0;
            case (state_q)
              ST_PRE:   state_d = (type_q == CMD_RESET) ? ST_DONE : ST_SHIFT;
              ST_SHIFT: state_d = ST_POST;
              default:  state_d = ST_DONE;
            endcase
          end
          if (state_q == ST_SHIFT) data_d = data_q >> 1;
          tms_d = tms_for(state_d, type_q, cnt_d, shift_len);
          tdi_d = (state_d == ST_SHIFT) && data_d[0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      type_q  <= CMD_RESET;
      cnt_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (busy),
    .tck_o  (TCK),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  assign TMS = tms_q;
  assign TDI = tdi_q;
endmodule
